// File: rtl/cgra0_input_stream_ctrl_pkg.sv
// cgra0_input_stream_ctrl_pkg: shared FSM encoding and default widths for the CGRA stream controllers
package cgra0_input_stream_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CNT_WIDTH = 32;
endpackage

// File: rtl/cgra0_sync_fifo.sv
// cgra0_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count
module cgra0_sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [DEPTH_LOG:0]    count,
    output logic                  full,
    output logic                  empty
);
    logic [DATA_WIDTH-1:0] mem [1 << DEPTH_LOG];
    logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (DEPTH_LOG + 1)'(1 << DEPTH_LOG);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
            if (do_pop) rd_ptr <= rd_ptr + DEPTH_LOG'(1);
            count <= count + (DEPTH_LOG + 1)'(do_push) - (DEPTH_LOG + 1)'(do_pop);
        end
    end
endmodule

// File: rtl/cgra0_input_stream_ctrl.sv
// cgra0_input_stream_ctrl: fetches num_data words from memory into a FIFO and streams them to the CGRA
module cgra0_input_stream_ctrl
    import cgra0_input_stream_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH_LOG = 3,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int POP_THRESHOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_data,
    input  logic                  en_fetch_data,
    output logic                  rd_req,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  available_read,
    output logic                  available_pop,
    output logic                  read_fifo_done
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam int CW = FIFO_DEPTH_LOG + 1;
    state_t state, state_nx;
    logic [CNT_WIDTH-1:0] num_q, req_cnt, pop_cnt, fetched_cnt;
    logic [CW-1:0] inflight, fifo_count;
    logic fifo_full, fifo_empty, push, pop, accept;
    assign accept = start && (state == IDLE || state == DONE);
    // a response with nothing outstanding is a protocol error and is dropped
    assign push = rd_valid && inflight != '0;
    assign pop = en && !fifo_empty;
    assign rd_req = state == FETCH && en_fetch_data && req_cnt < num_q && !fifo_full &&
                    ({1'b0, fifo_count} + {1'b0, inflight} < (CW + 1)'(DEPTH));
    assign read_fifo_done = state == DONE;
    cgra0_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG(FIFO_DEPTH_LOG)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .din(rd_data),
        .dout(dout),
        .count(fifo_count),
        .full(fifo_full),
        .empty(fifo_empty)
    );
    always_comb begin
        state_nx = state;
        if (accept) state_nx = num_data == '0 ? DONE : FETCH;
        else if (state == FETCH && req_cnt == num_q) state_nx = DRAIN;
        else if (state == DRAIN && pop_cnt + CNT_WIDTH'(pop) == num_q) state_nx = DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            num_q <= '0;
            req_cnt <= '0;
            pop_cnt <= '0;
            fetched_cnt <= '0;
            inflight <= '0;
            available_read <= 1'b0;
            available_pop <= 1'b0;
        end else begin
            state <= state_nx;
            available_read <= fifo_count != '0;
            available_pop <= fifo_count >= CW'(POP_THRESHOLD) || (fifo_count != '0 && fetched_cnt == num_q);
            inflight <= inflight + CW'(rd_req) - CW'(push);
            if (accept) begin
                num_q <= num_data;
                req_cnt <= '0;
                pop_cnt <= '0;
                fetched_cnt <= '0;
            end else begin
                req_cnt <= req_cnt + CNT_WIDTH'(rd_req);
                pop_cnt <= pop_cnt + CNT_WIDTH'(pop);
                fetched_cnt <= fetched_cnt + CNT_WIDTH'(push);
            end
        end
    end
endmodule

// File: tb/tb_cgra0_input_stream_ctrl.sv
// tb_cgra0_input_stream_ctrl: directed vectors and corner sequences against a word-order scoreboard
module tb_cgra0_input_stream_ctrl;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, en_fetch_data = 1'b1, rd_valid = 1'b0, en = 1'b0;
    logic [31:0] num_data = '0;
    logic [15:0] rd_data = '0;
    logic rd_req, available_read, available_pop, read_fifo_done;
    logic [15:0] dout;
    int errors = 0, checks = 0, nreq = 0, npop = 0, m_infl = 0;
    logic p0_v = 1'b0, spur = 1'b0;
    logic [15:0] p0_d = '0, seq = '0;
    logic [15:0] m_fifo[$];

    typedef struct {
        logic [31:0] num;
        int          en_off;
        int          exp_reqs;
    } vec_t;
    vec_t vecs[5];

    cgra0_input_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .num_data(num_data), .en_fetch_data(en_fetch_data),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .en(en), .dout(dout),
        .available_read(available_read), .available_pop(available_pop), .read_fifo_done(read_fifo_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock: score this cycle's pop/push, then drive the memory response two cycles after its request
    task automatic cyc();
        logic req, pop, push;
        req = rd_req;
        pop = en && m_fifo.size() > 0;
        push = rd_valid && m_infl > 0;
        if (rst) begin
            m_fifo.delete();
            m_infl = 0;
            p0_v = 1'b0;
            req = 1'b0;
            pop = 1'b0;
            push = 1'b0;
        end
        if (pop) begin
            chk("dout", {16'h0, dout}, {16'h0, m_fifo[0]});
            void'(m_fifo.pop_front());
            npop++;
        end
        if (push) m_fifo.push_back(rd_data);
        m_infl += int'(req) - int'(push);
        if (req) nreq++;
        @(posedge clk);
        #1;
        rd_valid = p0_v || spur;
        rd_data = spur ? 16'hDEAD : p0_d;
        p0_v = req;
        p0_d = 16'hA000 + seq;
        if (req) seq++;
    endtask

    task automatic kick(input logic [31:0] n);
        nreq = 0;
        npop = 0;
        num_data = n;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_to_done(input string name);
        for (int k = 0; k < 600 && !read_fifo_done; k++) cyc();
        chk({name, "_done"}, {31'h0, read_fifo_done}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{num: 32'd5, en_off: 0, exp_reqs: 5};
        vecs[1] = '{num: 32'd1, en_off: 0, exp_reqs: 1};
        vecs[2] = '{num: 32'd8, en_off: 10, exp_reqs: 8};
        vecs[3] = '{num: 32'd9, en_off: 12, exp_reqs: 9};
        vecs[4] = '{num: 32'd3, en_off: 15, exp_reqs: 3};
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_req", {31'h0, rd_req}, 32'd0);
        chk("rst_dout", {16'h0, dout}, 32'd0);
        chk("rst_aread", {31'h0, available_read}, 32'd0);
        chk("rst_apop", {31'h0, available_pop}, 32'd0);
        chk("rst_done", {31'h0, read_fifo_done}, 32'd0);

        foreach (vecs[i]) begin
            en = 1'b0;
            kick(vecs[i].num);
            en = vecs[i].en_off == 0;
            for (int k = 0; k < vecs[i].en_off; k++) cyc();
            if (vecs[i].en_off > 0) chk("vec_held_aread", {31'h0, available_read}, 32'd1);
            en = 1'b1;
            run_to_done("vec");
            cyc();
            chk("vec_reqs", nreq, vecs[i].exp_reqs);
            chk("vec_pops", npop, vecs[i].exp_reqs);
            chk("vec_aread_end", {31'h0, available_read}, 32'd0);
            chk("vec_apop_end", {31'h0, available_pop}, 32'd0);
            chk("vec_done_held", {31'h0, read_fifo_done}, 32'd1);
        end

        en = 1'b0;
        kick(32'd20);
        for (int k = 0; k < 20; k++) cyc();
        chk("bp_reqs", nreq, 32'd8);
        chk("bp_req_off", {31'h0, rd_req}, 32'd0);
        chk("bp_apop", {31'h0, available_pop}, 32'd1);
        en = 1'b1;
        run_to_done("bp");
        chk("bp_total", nreq, 32'd20);
        chk("bp_pops", npop, 32'd20);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("zero_pre_done", {31'h0, read_fifo_done}, 32'd0);
        kick(32'd0);
        chk("zero_done", {31'h0, read_fifo_done}, 32'd1);
        repeat (3) cyc();
        chk("zero_reqs", nreq, 32'd0);

        en = 1'b0;
        kick(32'd3);
        for (int k = 0; k < 12; k++) cyc();
        chk("tail_apop", {31'h0, available_pop}, 32'd1);
        chk("tail_reqs", nreq, 32'd3);
        en = 1'b1;
        run_to_done("tail");
        chk("tail_pops", npop, 32'd3);

        en = 1'b0;
        kick(32'd20);
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_req", {31'h0, rd_req}, 32'd0);
        chk("mid_rst_dout", {16'h0, dout}, 32'd0);
        chk("mid_rst_aread", {31'h0, available_read}, 32'd0);
        chk("mid_rst_apop", {31'h0, available_pop}, 32'd0);
        chk("mid_rst_done", {31'h0, read_fifo_done}, 32'd0);
        en = 1'b1;
        kick(32'd2);
        run_to_done("restart");
        chk("restart_reqs", nreq, 32'd2);
        chk("restart_pops", npop, 32'd2);

        kick(32'd6);
        cyc();
        num_data = 32'd3;
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_to_done("ign");
        chk("ign_reqs", nreq, 32'd6);
        chk("ign_pops", npop, 32'd6);
        spur = 1'b1;
        cyc();
        spur = 1'b0;
        repeat (3) cyc();
        chk("spur_aread", {31'h0, available_read}, 32'd0);
        chk("spur_dout", {16'h0, dout}, 32'd0);
        chk("spur_done", {31'h0, read_fifo_done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
